// File: rtl/pipe_ctrl_unit_if.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_unit_if
//   Bundle between the 5-stage datapath and the pipelined control unit.
//   master : datapath side (drives ID instruction / EX zero flag, consumes
//            hazard controls and per-stage control bits)
//   slave  : control unit side
// Signals
//   id_valid, id_instr, ex_zero            datapath -> control
//   stall, flush, pc_src                   hazard/branch controls (comb)
//   ex_alu_ctrl, ex_alu_src, ex_illegal    EX stage controls
//   mem_read, mem_write                    MEM stage controls
//   wb_reg_write, wb_mem_reg, wb_wr_reg    WB stage controls
// ----------------------------------------------------------------------------
interface pipe_ctrl_unit_if #(
    parameter int REG_AW     = 5,
    parameter int ALU_CTRL_W = 4
);
    logic                  id_valid;
    logic [31:0]           id_instr;
    logic                  ex_zero;
    logic                  stall;
    logic                  flush;
    logic                  pc_src;
    logic [ALU_CTRL_W-1:0] ex_alu_ctrl;
    logic                  ex_alu_src;
    logic                  ex_illegal;
    logic                  mem_read;
    logic                  mem_write;
    logic                  wb_reg_write;
    logic                  wb_mem_reg;
    logic [REG_AW-1:0]     wb_wr_reg;

    modport master (
        output id_valid, id_instr, ex_zero,
        input  stall, flush, pc_src,
        input  ex_alu_ctrl, ex_alu_src, ex_illegal,
        input  mem_read, mem_write,
        input  wb_reg_write, wb_mem_reg, wb_wr_reg
    );

    modport slave (
        input  id_valid, id_instr, ex_zero,
        output stall, flush, pc_src,
        output ex_alu_ctrl, ex_alu_src, ex_illegal,
        output mem_read, mem_write,
        output wb_reg_write, wb_mem_reg, wb_wr_reg
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_unit
//   Pipelined main/ALU decoder for the 5-stage MIPS core. Decodes the ID
//   instruction, carries its control bits through ID/EX, EX/MEM and MEM/WB,
//   raises a one-cycle stall on a load-use hazard and a flush when a BEQ/BNE
//   resolves taken in EX.
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high; all stages load a bubble
//   bus        pipe_ctrl_unit_if.slave (ID instruction in, per-stage controls
//              and stall/flush/pc_src out)
// Optional feature
//   CTRL_IMM_OPS_EN : when defined, ADDI/ANDI/ORI decode as immediate ALU ops;
//                     otherwise those opcodes decode as illegal.
// ----------------------------------------------------------------------------
module pipe_ctrl_unit #(
    parameter int                    REG_AW      = 5,
    parameter int                    ALU_CTRL_W  = 4,
    parameter logic [ALU_CTRL_W-1:0] ALU_ILLEGAL = {ALU_CTRL_W{1'b1}}
) (
    input  logic            clock,
    input  logic            reset,
    pipe_ctrl_unit_if.slave bus
);

    // opcodes
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
`ifdef CTRL_IMM_OPS_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
`endif

    // R-type functs
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // ALU codes
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(4'b0000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(4'b0001);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'b0110);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(4'b0111);
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = ALU_CTRL_W'(4'b1100);

    typedef struct packed {
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  alu_src;
        logic                  illegal;
        logic                  is_beq;
        logic                  is_bne;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  mem_reg;
        logic [REG_AW-1:0]     wr_reg;
    } id_ex_t;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_reg;
        logic [REG_AW-1:0] wr_reg;
    } ex_mem_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_reg;
        logic [REG_AW-1:0] wr_reg;
    } mem_wb_t;

    id_ex_t  dec;
    id_ex_t  id_ex_q;
    ex_mem_t ex_mem_q;
    mem_wb_t mem_wb_q;

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              uses_rt;
    logic              load_use;
    logic              taken;
    logic              stall_i;
    logic              flush_i;

    assign op    = bus.id_instr[31:26];
    assign funct = bus.id_instr[5:0];
    assign rs    = REG_AW'(bus.id_instr[25:21]);
    assign rt    = REG_AW'(bus.id_instr[20:16]);
    assign rd    = REG_AW'(bus.id_instr[15:11]);

    // ------------------------------------------------------------------
    // ID decode. A non-valid slot decodes to the all-zero bubble.
    // ------------------------------------------------------------------
    always_comb begin
        dec = '0;
        if (bus.id_valid) begin
            case (op)
                OP_R: begin
                    dec.reg_write = 1'b1;
                    dec.wr_reg    = rd;
                    case (funct)
                        FN_AND:  dec.alu_ctrl = ALU_AND;
                        FN_OR:   dec.alu_ctrl = ALU_OR;
                        FN_ADD:  dec.alu_ctrl = ALU_ADD;
                        FN_SUB:  dec.alu_ctrl = ALU_SUB;
                        FN_SLT:  dec.alu_ctrl = ALU_SLT;
                        FN_NOR:  dec.alu_ctrl = ALU_NOR;
                        default: begin
                            dec.reg_write = 1'b0;
                            dec.wr_reg    = '0;
                            dec.illegal   = 1'b1;
                            dec.alu_ctrl  = ALU_ILLEGAL;
                        end
                    endcase
                end
                OP_LW: begin
                    dec.alu_ctrl  = ALU_ADD;
                    dec.alu_src   = 1'b1;
                    dec.mem_read  = 1'b1;
                    dec.mem_reg   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.wr_reg    = rt;
                end
                OP_SW: begin
                    dec.alu_ctrl  = ALU_ADD;
                    dec.alu_src   = 1'b1;
                    dec.mem_write = 1'b1;
                end
                OP_BEQ: begin
                    dec.alu_ctrl = ALU_SUB;
                    dec.is_beq   = 1'b1;
                end
                OP_BNE: begin
                    dec.alu_ctrl = ALU_SUB;
                    dec.is_bne   = 1'b1;
                end
`ifdef CTRL_IMM_OPS_EN
                OP_ADDI, OP_ANDI, OP_ORI: begin
                    dec.alu_ctrl  = (op == OP_ADDI) ? ALU_ADD :
                                    (op == OP_ANDI) ? ALU_AND : ALU_OR;
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.wr_reg    = rt;
                end
`endif
                default: begin
                    // undefined opcode: no enables, ALU code left at 0000
                    dec.illegal = 1'b1;
                end
            endcase
            // $zero is never written
            if (dec.wr_reg == '0)
                dec.reg_write = 1'b0;
        end
    end

    // rt is a source operand for R-type, SW and both branches; LW and the
    // immediate ops only read rs.
    assign uses_rt = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);

    // Only LW sets mem_read, so it doubles as the "EX holds a load" flag.
    assign load_use = bus.id_valid && id_ex_q.mem_read && (id_ex_q.wr_reg != '0) &&
                      ((id_ex_q.wr_reg == rs) || (uses_rt && (id_ex_q.wr_reg == rt)));

    assign taken = (id_ex_q.is_beq && bus.ex_zero) || (id_ex_q.is_bne && !bus.ex_zero);

    // A taken branch squashes the ID instruction anyway, so it overrides
    // the stall. Both are held low while reset is asserted.
    assign flush_i = !reset && taken;
    assign stall_i = !reset && load_use && !taken;

    // ------------------------------------------------------------------
    // Pipeline registers: advance every cycle, ID/EX takes a bubble on
    // stall or flush.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q            <= (stall_i || flush_i) ? '0 : dec;
            ex_mem_q.mem_read  <= id_ex_q.mem_read;
            ex_mem_q.mem_write <= id_ex_q.mem_write;
            ex_mem_q.reg_write <= id_ex_q.reg_write;
            ex_mem_q.mem_reg   <= id_ex_q.mem_reg;
            ex_mem_q.wr_reg    <= id_ex_q.wr_reg;
            mem_wb_q.reg_write <= ex_mem_q.reg_write;
            mem_wb_q.mem_reg   <= ex_mem_q.mem_reg;
            mem_wb_q.wr_reg    <= ex_mem_q.wr_reg;
        end
    end

    assign bus.stall        = stall_i;
    assign bus.flush        = flush_i;
    assign bus.pc_src       = flush_i;
    assign bus.ex_alu_ctrl  = id_ex_q.alu_ctrl;
    assign bus.ex_alu_src   = id_ex_q.alu_src;
    assign bus.ex_illegal   = id_ex_q.illegal;
    assign bus.mem_read     = ex_mem_q.mem_read;
    assign bus.mem_write    = ex_mem_q.mem_write;
    assign bus.wb_reg_write = mem_wb_q.reg_write;
    assign bus.wb_mem_reg   = mem_wb_q.mem_reg;
    assign bus.wb_wr_reg    = mem_wb_q.wr_reg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl_unit
//   Directed scenarios followed by a randomized instruction stream, all
//   compared cycle by cycle against a stage-occupancy model (what sits in
//   EX / MEM / WB, derived from the MIPS decode table).
// ----------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipe_ctrl_unit_if #(.REG_AW(5), .ALU_CTRL_W(4)) bus ();

    pipe_ctrl_unit #(.REG_AW(5), .ALU_CTRL_W(4), .ALU_ILLEGAL(4'b1111)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [3:0] alu;
        logic       src, ill, beq, bne, mr, mw, rw, mreg;
        logic [4:0] wr;
    } rec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    rec_t m_ex = '0, m_mem = '0, m_wb = '0;
    logic obs_stall, obs_flush, obs_pc_src, exp_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt);
        return {op, rs, rt, 16'h1234};
    endfunction

    // Control word an instruction carries once it has entered EX.
    function automatic rec_t decode(logic v, logic [31:0] ins);
        rec_t       r;
        logic [5:0] op;
        logic [5:0] fn;
        r  = '0;
        op = ins[31:26];
        fn = ins[5:0];
        if (!v) return r;
        case (op)
            6'b000000: begin
                r.rw = 1'b1;
                r.wr = ins[15:11];
                case (fn)
                    6'b100100: r.alu = 4'b0000;
                    6'b100101: r.alu = 4'b0001;
                    6'b100000: r.alu = 4'b0010;
                    6'b100010: r.alu = 4'b0110;
                    6'b101010: r.alu = 4'b0111;
                    6'b100111: r.alu = 4'b1100;
                    default: begin r.rw = 1'b0; r.wr = 5'd0; r.ill = 1'b1; r.alu = 4'b1111; end
                endcase
            end
            LW:  begin r.alu = 4'b0010; r.src = 1'b1; r.mr = 1'b1; r.mreg = 1'b1; r.rw = 1'b1; r.wr = ins[20:16]; end
            SW:  begin r.alu = 4'b0010; r.src = 1'b1; r.mw = 1'b1; end
            BEQ: begin r.alu = 4'b0110; r.beq = 1'b1; end
            BNE: begin r.alu = 4'b0110; r.bne = 1'b1; end
`ifdef CTRL_IMM_OPS_EN
            ADDI: begin r.alu = 4'b0010; r.src = 1'b1; r.rw = 1'b1; r.wr = ins[20:16]; end
            ANDI: begin r.alu = 4'b0000; r.src = 1'b1; r.rw = 1'b1; r.wr = ins[20:16]; end
            ORI:  begin r.alu = 4'b0001; r.src = 1'b1; r.rw = 1'b1; r.wr = ins[20:16]; end
`endif
            default: r.ill = 1'b1;
        endcase
        if (r.wr == 5'd0) r.rw = 1'b0;
        return r;
    endfunction

    function automatic logic reads_rt(logic [5:0] op);
        return (op == 6'b000000) || (op == SW) || (op == BEQ) || (op == BNE);
    endfunction

    // One clock: drive at posedge+1, compare at negedge, advance model.
    task automatic cycle(input logic rst, input logic v, input logic [31:0] ins, input logic z);
        logic tk;
        logic st;
        reset         = rst;
        bus.id_valid  = v;
        bus.id_instr  = ins;
        bus.ex_zero   = z;
        @(negedge clock);
        tk = !rst && ((m_ex.beq && z) || (m_ex.bne && !z));
        st = !rst && !tk && v && m_ex.mr && (m_ex.wr != 5'd0) &&
             ((m_ex.wr == ins[25:21]) || (reads_rt(ins[31:26]) && (m_ex.wr == ins[20:16])));
        obs_stall  = bus.stall;
        obs_flush  = bus.flush;
        obs_pc_src = bus.pc_src;
        exp_stall  = st;
        chk("stall",        bus.stall,        st);
        chk("flush",        bus.flush,        tk);
        chk("pc_src",       bus.pc_src,       tk);
        chk("ex_alu_ctrl",  bus.ex_alu_ctrl,  m_ex.alu);
        chk("ex_alu_src",   bus.ex_alu_src,   m_ex.src);
        chk("ex_illegal",   bus.ex_illegal,   m_ex.ill);
        chk("mem_read",     bus.mem_read,     m_mem.mr);
        chk("mem_write",    bus.mem_write,    m_mem.mw);
        chk("wb_reg_write", bus.wb_reg_write, m_wb.rw);
        chk("wb_mem_reg",   bus.wb_mem_reg,   m_wb.mreg);
        chk("wb_wr_reg",    bus.wb_wr_reg,    m_wb.wr);
        @(posedge clock);
        #1;
        cyc++;
        m_wb  = rst ? '0 : m_mem;
        m_mem = rst ? '0 : m_ex;
        m_ex  = (rst || tk || st) ? '0 : decode(v, ins);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [5:0] fns [6] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b100111};
        logic [5:0] imm [3] = '{ADDI, ANDI, ORI};
        logic [4:0] rs, rt, rd;
        logic [5:0] fn;
        int k;
        rs = 5'($urandom_range(0, 4));
        rt = 5'($urandom_range(0, 4));
        rd = 5'($urandom_range(0, 4));
        k  = $urandom_range(0, 9);
        fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
        case (k)
            0, 1, 2: return r_ins(fn, rs, rt, rd);
            3, 4:    return i_ins(LW, rs, rt);
            5:       return i_ins(SW, rs, rt);
            6:       return i_ins(BEQ, rs, rt);
            7:       return i_ins(BNE, rs, rt);
            8:       return i_ins(imm[$urandom_range(0, 2)], rs, rt);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ins;
        logic        v;

        reset        = 1'b1;
        bus.id_valid = 1'b0;
        bus.id_instr = '0;
        bus.ex_zero  = 1'b0;
        @(posedge clock);
        #1;

        // reset held with random traffic, then first cycle after release
        cycle(1'b1, 1'b1, $urandom, 1'($urandom));
        cycle(1'b1, 1'b1, $urandom, 1'($urandom));
        chk("rst_ex_alu", bus.ex_alu_ctrl, 4'b0000);
        chk("rst_wb_we",  bus.wb_reg_write, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);

        // R add 1,2 -> 3: EX one cycle later, WB three cycles later
        cycle(1'b0, 1'b1, r_ins(6'b100000, 5'd1, 5'd2, 5'd3), 1'b0);
        chk("add_ex_alu", bus.ex_alu_ctrl, 4'b0010);
        chk("add_ex_src", bus.ex_alu_src, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        chk("add_wb_we",  bus.wb_reg_write, 1'b1);
        chk("add_wb_reg", bus.wb_wr_reg, 5'd3);
        chk("add_wb_mr",  bus.wb_mem_reg, 1'b0);

        // load-use: exactly one stall, then the held add enters EX
        cycle(1'b0, 1'b1, i_ins(LW, 5'd1, 5'd5), 1'b0);
        cycle(1'b0, 1'b1, r_ins(6'b100000, 5'd5, 5'd2, 5'd6), 1'b0);
        chk("lu_stall",  obs_stall, 1'b1);
        chk("lu_bubble", bus.ex_alu_ctrl, 4'b0000);
        cycle(1'b0, 1'b1, r_ins(6'b100000, 5'd5, 5'd2, 5'd6), 1'b0);
        chk("lu_once",   obs_stall, 1'b0);
        chk("lu_add_ex", bus.ex_alu_ctrl, 4'b0010);
        cycle(1'b0, 1'b1, i_ins(LW, 5'd1, 5'd0), 1'b0);
        cycle(1'b0, 1'b1, r_ins(6'b100000, 5'd0, 5'd0, 5'd6), 1'b0);
        chk("lw_r0_nostall", obs_stall, 1'b0);

        // BEQ taken flushes; BNE with zero=1 does not
        cycle(1'b0, 1'b1, i_ins(BEQ, 5'd1, 5'd2), 1'b0);
        cycle(1'b0, 1'b1, r_ins(6'b100000, 5'd1, 5'd2, 5'd3), 1'b1);
        chk("beq_flush",  obs_flush, 1'b1);
        chk("beq_pc_src", obs_pc_src, 1'b1);
        chk("beq_bubble", bus.ex_alu_ctrl, 4'b0000);
        cycle(1'b0, 1'b1, i_ins(BNE, 5'd1, 5'd2), 1'b0);
        cycle(1'b0, 1'b1, r_ins(6'b100000, 5'd1, 5'd2, 5'd3), 1'b1);
        chk("bne_noflush", obs_flush, 1'b0);
        chk("bne_add_ex",  bus.ex_alu_ctrl, 4'b0010);

        // taken branch while ID reads the pending load target
        cycle(1'b0, 1'b1, i_ins(LW, 5'd1, 5'd4), 1'b0);
        cycle(1'b0, 1'b1, i_ins(BEQ, 5'd1, 5'd2), 1'b0);
        cycle(1'b0, 1'b1, r_ins(6'b100000, 5'd4, 5'd2, 5'd3), 1'b1);
        chk("fs_flush",  obs_flush, 1'b1);
        chk("fs_stall",  obs_stall, 1'b0);
        chk("fs_bubble", bus.ex_alu_ctrl, 4'b0000);

        // undefined opcode and undefined funct
        cycle(1'b0, 1'b1, i_ins(6'b111111, 5'd1, 5'd2), 1'b0);
        chk("ill_op_flag", bus.ex_illegal, 1'b1);
        chk("ill_op_alu",  bus.ex_alu_ctrl, 4'b0000);
        cycle(1'b0, 1'b1, r_ins(6'b111000, 5'd1, 5'd2, 5'd3), 1'b0);
        chk("ill_op_mw",   bus.mem_write, 1'b0);
        chk("ill_fn_flag", bus.ex_illegal, 1'b1);
        chk("ill_fn_alu",  bus.ex_alu_ctrl, 4'b1111);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        chk("ill_fn_we",   bus.wb_reg_write, 1'b0);

        // ADDI rt=7
        cycle(1'b0, 1'b1, i_ins(ADDI, 5'd1, 5'd7), 1'b0);
`ifdef CTRL_IMM_OPS_EN
        chk("addi_src", bus.ex_alu_src, 1'b1);
        chk("addi_alu", bus.ex_alu_ctrl, 4'b0010);
`else
        chk("addi_ill", bus.ex_illegal, 1'b1);
        chk("addi_src", bus.ex_alu_src, 1'b0);
`endif
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
`ifdef CTRL_IMM_OPS_EN
        chk("addi_wb_reg", bus.wb_wr_reg, 5'd7);
        chk("addi_wb_we",  bus.wb_reg_write, 1'b1);
`else
        chk("addi_wb_we",  bus.wb_reg_write, 1'b0);
`endif

        // reset in the middle of a load-use pair discards everything
        cycle(1'b0, 1'b1, r_ins(6'b100000, 5'd1, 5'd2, 5'd3), 1'b0);
        cycle(1'b0, 1'b1, i_ins(LW, 5'd1, 5'd4), 1'b0);
        cycle(1'b1, 1'b1, r_ins(6'b100000, 5'd4, 5'd2, 5'd5), 1'b0);
        chk("mid_rst_stall", obs_stall, 1'b0);
        chk("mid_rst_ex",    bus.ex_alu_ctrl, 4'b0000);
        chk("mid_rst_mem",   bus.mem_read, 1'b0);
        chk("mid_rst_wb",    bus.wb_reg_write, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);

        // random stream; a stalled ID instruction is re-presented
        ins = 32'd0;
        v   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!exp_stall) begin
                ins = rnd_instr();
                v   = ($urandom_range(0, 9) != 0);
            end
            cycle(($urandom_range(0, 49) == 0), v, ins, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
